// File: rtl/mem_update_arbiter.sv
// Round-robin arbiter granting NREQ requesters single-word memory updates,
// with per-transaction completion timeout and a one-cycle fairness mask.
module mem_update_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              HRESET,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_done,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              timeout_err
);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("mem_update_arbiter: NREQ must be 2..8");
        end
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("mem_update_arbiter: TIMEOUT must be 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT,
        ACK
    } state_t;

    state_t          state;
    logic [2:0]      rr_ptr;
    logic [7:0]      cnt;
    logic [NREQ-1:0] mask;

    logic [NREQ-1:0] elig;
    logic [7:0]      elig8;
    logic [2:0]      pick;
    logic            pick_ok;
    logic [3:0]      pos;
    logic [2:0]      grant_nxt;
    logic [7:0]      grant_oh;

    assign elig     = req & ~mask;
    assign elig8    = 8'(elig);
    assign grant_oh = 8'd1 << grant_id;

    assign grant_nxt = (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;

    // Scan from the farthest offset down so the nearest eligible one wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        pos     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + 4'(k);
            if (pos >= 4'(NREQ)) begin
                pos = pos - 4'(NREQ);
            end
            if (elig8[pos[2:0]]) begin
                pick    = pos[2:0];
                pick_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cnt         <= '0;
            mask        <= '0;
            ack         <= '0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    mask <= '0;
                    if (pick_ok) begin
                        mem_addr  <= req_addr[int'(pick)*AW +: AW];
                        mem_wdata <= req_data[int'(pick)*DW +: DW];
                        grant_id  <= pick;
                        mem_wr    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_wr <= 1'b0;
                    cnt    <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over an expiring counter.
                    if (mem_done) begin
                        ack   <= grant_oh[NREQ-1:0];
                        state <= ACK;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        rr_ptr      <= grant_nxt;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ACK: begin
                    ack    <= '0;
                    rr_ptr <= grant_nxt;
                    mask   <= grant_oh[NREQ-1:0];
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_update_arbiter.sv
// Scoreboard bench for mem_update_arbiter: stimulus queues expected writes
// and acks, a negedge monitor pops and compares them as the DUT emits them.
module tb_mem_update_arbiter;

    logic        clk = 1'b0;
    logic        HRESET;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [127:0] req_data;
    logic [3:0]  ack;
    logic        mem_wr;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic        busy;
    logic [2:0]  grant_id;
    logic        timeout_err;

    mem_update_arbiter #(
        .NREQ(4), .AW(8), .DW(32), .TIMEOUT(15)
    ) dut (
        .clk(clk),
        .HRESET(HRESET),
        .req(req),
        .req_addr(req_addr),
        .req_data(req_data),
        .ack(ack),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_done(mem_done),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    txn_t exp_wr[$];
    txn_t exp_ack[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int done_delay = 1;
    bit auto_drop = 1'b0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic push(int id, logic [7:0] a, logic [31:0] d, int wcyc, int acyc);
        txn_t t;
        t.id = id; t.addr = a; t.data = d;
        t.cyc = wcyc;
        exp_wr.push_back(t);
        if (acyc >= 0) begin
            t.cyc = acyc;
            exp_ack.push_back(t);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_wr.size() != 0 || exp_ack.size() != 0) && n < 200) begin
            step();
            n++;
        end
        n_vec++;
        if (n >= 200) begin
            n_err++;
            $display("FAIL idle_timeout: got busy after %0d cycles want idle", n);
        end
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        req = '0;
        step();
        step();
        HRESET = 1'b0;
        step();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: mem_done pulses in the done_delay-th cycle after mem_wr.
    initial begin
        int cd;
        cd = 0;
        mem_done = 1'b0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (HRESET) cd = 0;
            else if (mem_wr) cd = done_delay;
            else if (cd != 0) begin
                cd--;
                if (cd == 0) mem_done = 1'b1;
            end
        end
    end

    initial begin
        txn_t t;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (mem_wr) begin
                if (exp_wr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_wr: got id %0d want none", grant_id);
                end else begin
                    t = exp_wr.pop_front();
                    check("wr_id", 64'(grant_id), 64'(t.id));
                    check("wr_addr", 64'(mem_addr), 64'(t.addr));
                    check("wr_data", 64'(mem_wdata), 64'(t.data));
                    check("wr_cycle", 64'(cyc), 64'(t.cyc));
                end
            end
            if (ack != 4'b0000) begin
                if (exp_ack.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_ack: got %b want 0000", ack);
                end else begin
                    t = exp_ack.pop_front();
                    oh = 4'b0001 << t.id;
                    check("ack_vec", 64'(ack), 64'(oh));
                    check("ack_addr", 64'(mem_addr), 64'(t.addr));
                    check("ack_data", 64'(mem_wdata), 64'(t.data));
                    check("ack_cycle", 64'(cyc), 64'(t.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int c;
        HRESET = 1'b1;
        req = '0;
        req_addr = '0;
        req_data = '0;
        repeat (3) step();
        HRESET = 1'b0;
        step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_mem_wr", 64'(mem_wr), 64'd0);
        check("rst_addr", 64'(mem_addr), 64'd0);
        check("rst_wdata", 64'(mem_wdata), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_terr", 64'(timeout_err), 64'd0);

        // single request, inputs disturbed and req dropped after grant
        done_delay = 1;
        c = cyc;
        req_addr[16 +: 8] = 8'h3C;
        req_data[64 +: 32] = 32'hDEADBEEF;
        req = 4'b0100;
        push(2, 8'h3C, 32'hDEADBEEF, c + 1, c + 3);
        step();
        req = '0;
        req_addr = '1;
        req_data = '0;
        wait_idle();
        check("single_grant", 64'(grant_id), 64'd2);

        // round robin from reset: 0,1,2,3 then wrap back to 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_addr[i*8 +: 8] = 8'(8'h10 + i);
            req_data[i*32 +: 32] = 32'hA0000000 + 32'(i);
        end
        auto_drop = 1'b1;
        c = cyc;
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push(k, 8'(8'h10 + k), 32'hA0000000 + 32'(k), c + 1 + 4*k, c + 3 + 4*k);
        end
        wait_idle();
        step();
        c = cyc;
        req = 4'b1001;
        push(0, 8'h10, 32'hA0000000, c + 1, c + 3);
        push(3, 8'h13, 32'hA0000003, c + 5, c + 7);
        wait_idle();
        check("rr_req_clear", 64'(req), 64'd0);

        // timeout: 15 WAIT cycles, no ack, sticky error, pointer advanced
        do_reset();
        auto_drop = 1'b0;
        done_delay = 0;
        req_addr[0 +: 8] = 8'h77;
        req_data[0 +: 32] = 32'h0BADF00D;
        c = cyc;
        req = 4'b0001;
        push(0, 8'h77, 32'h0BADF00D, c + 1, -1);
        repeat (16) step();
        check("to_busy_last_wait", 64'(busy), 64'd1);
        check("to_err_before", 64'(timeout_err), 64'd0);
        step();
        check("to_busy_idle", 64'(busy), 64'd0);
        check("to_err_set", 64'(timeout_err), 64'd1);
        req = '0;
        repeat (3) step();
        check("to_err_sticky", 64'(timeout_err), 64'd1);
        done_delay = 1;
        auto_drop = 1'b1;
        req_addr[0 +: 16] = 16'h0201;
        req_data[0 +: 64] = 64'h22222222_11111111;
        c = cyc;
        req = 4'b0011;
        push(1, 8'h02, 32'h22222222, c + 1, c + 3);
        push(0, 8'h01, 32'h11111111, c + 5, c + 7);
        wait_idle();
        check("to_err_kept", 64'(timeout_err), 64'd1);

        // mem_done coincides with counter at TIMEOUT-1
        do_reset();
        done_delay = 15;
        req_addr[0 +: 8] = 8'h44;
        req_data[0 +: 32] = 32'h12345678;
        c = cyc;
        req = 4'b0001;
        push(0, 8'h44, 32'h12345678, c + 1, c + 17);
        wait_idle();
        check("tie_terr", 64'(timeout_err), 64'd0);

        // fairness mask: requester 1 keeps req after its ack
        do_reset();
        done_delay = 1;
        auto_drop = 1'b0;
        req_addr[8 +: 8] = 8'h21;
        req_data[32 +: 32] = 32'hCAFE0001;
        c = cyc;
        req = 4'b0010;
        push(1, 8'h21, 32'hCAFE0001, c + 1, c + 3);
        push(1, 8'h21, 32'hCAFE0001, c + 6, c + 8);
        repeat (4) step();
        check("mask_idle0", 64'(busy), 64'd0);
        step();
        check("mask_idle1", 64'(busy), 64'd0);
        step();
        check("mask_regrant", 64'(busy), 64'd1);
        repeat (2) step();
        req = '0;
        wait_idle();

        // reset in the middle of WAIT
        done_delay = 0;
        req_addr[16 +: 8] = 8'h5A;
        req_data[64 +: 32] = 32'h5555AAAA;
        c = cyc;
        req = 4'b0100;
        push(2, 8'h5A, 32'h5555AAAA, c + 1, -1);
        repeat (3) step();
        check("mid_busy", 64'(busy), 64'd1);
        HRESET = 1'b1;
        req = '0;
        step();
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_addr", 64'(mem_addr), 64'd0);
        check("mid_rst_wdata", 64'(mem_wdata), 64'd0);
        check("mid_rst_grant", 64'(grant_id), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        HRESET = 1'b0;
        repeat (20) step();

        check("left_wr", 64'(exp_wr.size()), 64'd0);
        check("left_ack", 64'(exp_ack.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
